// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester (IF/LS) handshakes and memory macro port of the arbiter.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic        ls_err;
  logic [31:0] ls_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_err, ls_rdata, mem_addr, mem_wr_en, mem_wdata, busy
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_err, ls_rdata, mem_addr, mem_wr_en, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory between fetch and load/store with sub-word extract/merge.
module mem_arbiter (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic        last_q, last_d, sel_q, sel_d, we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic        pick_ls, mis;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ext, merged;
  // last_q/sel_q: 1 = LS; on conflict the side not granted last wins
  assign pick_ls = bus.ls_req & (~bus.if_req | ~last_q);
  assign mis = bus.ls_size == 2'b11 | (bus.ls_size == 2'b01 & bus.ls_addr[0]) |
               (bus.ls_size == 2'b10 & (|bus.ls_addr[1:0]));
  assign bsel = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign hsel = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign ext = size_q == 2'b00 ? {{24{~uns_q & bsel[7]}}, bsel} :
               size_q == 2'b01 ? {{16{~uns_q & hsel[15]}}, hsel} : bus.mem_rdata;
  // wdata_q still holds the raw store data until the merged word replaces it
  always_comb begin
    merged = bus.mem_rdata;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    we_d       = we_q;
    uns_d      = uns_q;
    err_d      = err_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    unique case (state_q)
      IDLE: if (bus.if_req | bus.ls_req) begin
        sel_d   = pick_ls;
        last_d  = pick_ls;
        addr_d  = pick_ls ? bus.ls_addr : bus.if_addr;
        size_d  = pick_ls ? bus.ls_size : 2'b10;
        we_d    = pick_ls & bus.ls_we;
        uns_d   = bus.ls_unsigned;
        err_d   = pick_ls & mis;
        wdata_d = pick_ls ? bus.ls_wdata : wdata_q;
        ls_rdata_d = pick_ls ? 32'h0 : ls_rdata_q;
        state_d = (pick_ls & mis) ? DONE : (pick_ls & bus.ls_we & bus.ls_size == 2'b10) ? WRITE : READ;
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        wdata_d    = we_q ? merged : wdata_q;
        ls_rdata_d = (~we_q & sel_q) ? ext : ls_rdata_q;
        if_rdata_d = (~we_q & ~sel_q) ? bus.mem_rdata : if_rdata_q;
        state_d    = we_q ? WRITE : DONE;
      end
      WRITE: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      ls_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      err_q      <= err_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end
  assign bus.if_ack    = state_q == DONE & ~sel_q;
  assign bus.ls_ack    = state_q == DONE & sel_q;
  assign bus.ls_err    = state_q == DONE & sel_q & err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wr_en = state_q == WRITE;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against a synchronous-read memory model with hand-computed expectations.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic [31:0] mem [64];
  int          wr_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          res_ack_c, res_wr_c, res_wr_n, wr_base;
  logic [31:0] res_rd, res_wd, res_addr1;
  logic        res_err, res_is_if;
  logic [7:0]  res_busy;
  logic [3:0]  order;
  int          n_ack;
  mem_arbiter_if bus();
  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (bus.mem_wr_en) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    bus.mem_rdata <= mem[bus.mem_addr[7:2]];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask
  task automatic drive(input logic is_if, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_size = size; bus.ls_unsigned = uns;
      bus.ls_addr = addr; bus.ls_wdata = wdata;
    end
  endtask
  task automatic await_ack();
    res_ack_c = -1; res_wr_c = -1; res_wr_n = 0; res_busy = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) res_addr1 = bus.mem_addr;
      if (c < 8) res_busy[c] = bus.busy;
      if (bus.mem_wr_en) begin
        res_wr_n++; res_wr_c = c; res_wd = bus.mem_wdata;
      end
      if (bus.if_ack | bus.ls_ack) begin
        res_ack_c = c; res_is_if = bus.if_ack; res_err = bus.ls_err;
        res_rd = bus.if_ack ? bus.if_rdata : bus.ls_rdata;
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        break;
      end
    end
    if (res_ack_c < 0) chk("ack_timeout", 32'd0, 32'd1);
  endtask
  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, 1'b0, size, uns, addr, 32'h0);
    await_ack();
    chk({tag, "_data"}, res_rd, exp);
    chk({tag, "_cyc"}, res_ack_c, 3);
  endtask
  task automatic chk_zero_outs(input string tag);
    chk({tag, "_flags"}, {bus.if_ack, bus.ls_ack, bus.ls_err, bus.mem_wr_en, bus.busy}, 5'b0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
    chk({tag, "_ls_rdata"}, bus.ls_rdata, 32'h0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0;
    bus.ls_unsigned = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    preload(6'd4, 32'h00A00093);
    preload(6'd8, 32'h80FF1234);
    chk_zero_outs("reset");
    // contention straight out of reset: LS must win first, then strict alternation
    @(negedge clk);
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b10; bus.ls_addr = 32'h20;
    n_ack = 0; order = '0;
    for (int c = 1; c <= 60 && n_ack < 4; c++) begin
      @(negedge clk);
      if (bus.if_ack | bus.ls_ack) begin
        order[n_ack] = bus.ls_ack;
        n_ack++;
      end
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    chk("arb_count", n_ack, 4);
    chk("arb_order", {28'h0, order}, 32'h5);
    // fetch
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    await_ack();
    chk("if_mem_addr", res_addr1, 32'h10);
    chk("if_ack_who", res_is_if, 1);
    chk("if_ack_cyc", res_ack_c, 3);
    chk("if_rdata", res_rd, 32'h00A00093);
    chk("if_busy", res_busy, 8'b0000_1110);
    @(negedge clk);
    chk("if_idle_busy", bus.busy, 0);
    // loads from 0x80FF1234
    load("lb", 2'b00, 1'b0, 32'h23, 32'hFFFFFF80);
    load("lbu", 2'b00, 1'b1, 32'h23, 32'h00000080);
    load("lh", 2'b01, 1'b0, 32'h22, 32'hFFFF80FF);
    load("lhu", 2'b01, 1'b1, 32'h20, 32'h00001234);
    load("lbu0", 2'b00, 1'b1, 32'h21, 32'h00000012);
    // misaligned / illegal
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    await_ack();
    chk("lw_mis_cyc", res_ack_c, 1);
    chk("lw_mis_err", res_err, 1);
    chk("lw_mis_rdata", res_rd, 32'h0);
    chk("lw_mis_wr", res_wr_n, 0);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h21, 32'hBEEF);
    await_ack();
    chk("sh_mis_cyc", res_ack_c, 1);
    chk("sh_mis_err", res_err, 1);
    chk("sh_mis_wr", res_wr_n, 0);
    chk("sh_mis_mem", mem[8], 32'h80FF1234);
    drive(1'b0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    await_ack();
    chk("ill_size_err", res_err, 1);
    // stores
    preload(6'd8, 32'h11223344);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hAB);
    await_ack();
    chk("sb_wr_n", res_wr_n, 1);
    chk("sb_wr_cyc", res_wr_c, 3);
    chk("sb_wdata", res_wd, 32'h1122AB44);
    chk("sb_ack_cyc", res_ack_c, 4);
    chk("sb_err", res_err, 0);
    chk("sb_rdata", res_rd, 32'h0);
    chk("sb_mem", mem[8], 32'h1122AB44);
    preload(6'd8, 32'h11223344);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hBEEF);
    await_ack();
    chk("sh_ack_cyc", res_ack_c, 4);
    chk("sh_mem", mem[8], 32'hBEEF3344);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    await_ack();
    chk("sw_wr_cyc", res_wr_c, 1);
    chk("sw_ack_cyc", res_ack_c, 2);
    chk("sw_mem", mem[8], 32'hCAFEF00D);
    // reset during CAPTURE of a byte store
    preload(6'd8, 32'h11223344);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hAB);
    wr_base = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk_zero_outs("mid_rst");
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_wr", wr_cnt - wr_base, 0);
    chk("mid_rst_mem", mem[8], 32'h11223344);
    rst = 1'b0;
    await_ack();
    chk("post_rst_ack_cyc", res_ack_c, 4);
    chk("post_rst_wr", wr_cnt - wr_base, 1);
    @(negedge clk);
    chk("post_rst_mem", mem[8], 32'h1122AB44);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port, word-wide data/instruction memory between instruction fetch (IF) and the load/store path (LS) of the core. Performs byte/halfword load extraction with sign or zero extension, and read-modify-write for byte/halfword stores. Enforces alignment rules and returns one acknowledge per accepted request. Sits between the control unit's memory interface (addr / mem_read / mem_write / wr_en) and the memory macro.

## Interface
- No parameters. Widths are fixed: 32-bit byte addresses and 32-bit data; the memory is little-endian and word-addressed through mem_addr[31:2].
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  32  fetched word; holds its value until the next fetch capture.
- ls_req  in  1  load/store request; held high with all ls_* inputs stable until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- ls_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- ls_addr  in  32  byte address.
- ls_wdata  in  32  store data; the low byte, low half, or full word is used according to ls_size.
- ls_ack  out  1  one-cycle completion pulse.
- ls_err  out  1  valid with ls_ack; 1 = misaligned or illegal size, and no memory access occurred.
- ls_rdata  out  32  load result, valid with ls_ack; 0 for stores and errors.
- mem_addr  out  32  word-aligned address to memory (bits [1:0] = 0).
- mem_wr_en  out  1  memory write strobe.
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read word; valid the cycle after mem_addr is presented with mem_wr_en = 0.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: arbitrate and latch the granted request (address, size, we, unsigned, wdata).
  - READ: memory read issued.
  - CAPTURE: mem_rdata valid.
  - WRITE: mem_wr_en = 1.
  - DONE: ack pulses.
- Arbitration happens in IDLE only.
  - One requester high: that requester is granted.
  - Both high: grant goes to the requester not granted last (last_grant register).
  - last_grant resets to IF, so LS wins the first conflict.
- Transitions from IDLE on grant:
  - Fetch or load: go to READ.
  - Word store: go to WRITE.
  - Misaligned or illegal request: go to DONE. A request is misaligned if it is a half with addr[0] = 1, a word with addr[1:0] ≠ 0, or has size 11.
- READ always goes to CAPTURE.
- CAPTURE:
  - Fetch or load: register the result, then go to DONE.
  - Sub-word store: register the merged word, then go to WRITE.
- WRITE goes to DONE.
- DONE pulses the granted requester's ack (and ls_err if applicable), then returns to IDLE.
- Load extraction (little-endian):
  - Byte lane is selected by addr[1:0]; halfword by addr[1] (0 = bits [15:0], 1 = bits [31:16]).
  - The result is extended to 32 bits per ls_unsigned.
  - Word loads pass mem_rdata unchanged.
- Store merge: only the addressed byte or half of mem_rdata is replaced with ls_wdata[7:0] or ls_wdata[15:0]; all other bits are preserved.
- mem_wr_en is high only in WRITE, exactly one cycle per store. Errored requests never touch memory.
- mem_addr = {latched_addr[31:2], 2'b00}, driven from the latch register in all states.
- Reset values: state IDLE, last_grant IF, and all outputs 0 (if_ack, ls_ack, ls_err, if_rdata, ls_rdata, mem_addr, mem_wr_en, mem_wdata, busy).
- Reset mid-operation: abort immediately and issue no write. The requester still holds req and is re-arbitrated once reset is released.
- Inputs that change while busy are ignored; only latched values are used.

## Timing
- Cycle 0 is the cycle in which IDLE samples req high.
- Fetch or load: READ c1, CAPTURE c2, ack in c3, next grant possible in c4.
- Word store: WRITE c1, ack in c2.
- Sub-word store: READ c1, CAPTURE c2, WRITE c3, ack in c4.
- Error: ack + ls_err in c1.
- No back-to-back acks. Acks occur only in DONE, and a requester whose ack is high cannot be re-granted until the following IDLE cycle, so a requester that drops req after its ack is never double-served.
- Under continuous contention, IF and LS alternate grants strictly.

## Test plan
- Fetch, mem[0x10] = 0x00A00093, if_addr = 0x13 → mem_addr = 0x10; if_ack in c3 with if_rdata = 0x00A00093; busy high c1–c3.
- Loads, mem[0x20] = 0x80FF1234:
  - lb @0x23 → ls_rdata = 0xFFFFFF80 (ack c3)
  - lbu @0x23 → 0x00000080
  - lh @0x22 → 0xFFFF80FF
  - lhu @0x20 → 0x00001234
- Stores, mem[0x20] = 0x11223344:
  - sb 0xAB @0x21 → single mem_wr_en pulse in c3 with 0x1122AB44; ack c4.
  - sh 0xBEEF @0x22 → 0xBEEF3344.
  - sw 0xCAFEF00D @0x20 → write in c1, ack c2.
- Misaligned lw @0x06 and sh @0x21 → ls_ack and ls_err in c1, ls_rdata = 0, no mem_wr_en, memory unchanged.
- Contention: both reqs held from the first cycle after reset → LS acked first, then IF; both re-requested repeatedly → grants alternate LS, IF, LS, IF.
- rst asserted during CAPTURE of an sb → all outputs 0 immediately, mem_wr_en never pulses, memory unchanged; after release the held request completes normally.
